// File: rtl/md5_round_engine.sv
// Iterative MD5 compression engine: 64 steps over one 512-bit block, UNROLL steps
// per clock, final chaining-value addition, valid/ready handshake on both sides.
module md5_round_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] indata,
  input  logic [127:0] link_var,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $fatal(1, "md5_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  localparam logic [31:0] K_TAB [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [0:15] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  // One MD5 step; state packed as {D, C, B, A}.
  function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] i,
                                            input logic [511:0] m);
    logic [31:0] a, b, c, d, f, t, tr;
    logic [3:0]  j, g;
    logic [4:0]  s;
    a = st[31:0];
    b = st[63:32];
    c = st[95:64];
    d = st[127:96];
    j = i[3:0];
    f = '0;
    g = '0;
    case (i[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = j;                 end
      2'd1: begin f = (d & b) | (~d & c); g = j * 4'd5 + 4'd1;   end
      2'd2: begin f = b ^ c ^ d;          g = j * 4'd3 + 4'd5;   end
      default: begin f = c ^ (b | ~d);    g = j * 4'd7;          end
    endcase
    s  = S_TAB[{i[5:4], i[1:0]}];
    t  = a + f + K_TAB[i] + m[{g, 5'd0} +: 32];
    tr = (t << s) | (t >> (6'd32 - {1'b0, s}));
    return {c, b, b + tr, d};
  endfunction

  state_t         state_reg, state_next;
  logic [5:0]     cnt_reg;
  logic [511:0]   msg_reg;
  logic [127:0]   save_reg;
  logic [127:0]   abcd_reg;
  logic [127:0]   result_reg;

  genvar gi;
  for (gi = 0; gi < UNROLL; gi++) begin : g_stage
    logic [127:0] st_in, st_out;
    if (gi == 0) begin : g_first
      assign st_in = abcd_reg;
    end else begin : g_chain
      assign st_in = g_stage[gi-1].st_out;
    end
    assign st_out = md5_step(st_in, cnt_reg + 6'(gi), msg_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST_CNT) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter wraps to 0 on the last RUN clock, so it is already clear for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      msg_reg    <= '0;
      save_reg   <= '0;
      abcd_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            msg_reg  <= indata;
            save_reg <= link_var;
            abcd_reg <= link_var;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          abcd_reg <= g_stage[UNROLL-1].st_out;
          cnt_reg  <= cnt_reg + 6'(UNROLL);
        end
        FIN: begin
          result_reg <= {abcd_reg[127:96] + save_reg[127:96],
                         abcd_reg[95:64]  + save_reg[95:64],
                         abcd_reg[63:32]  + save_reg[63:32],
                         abcd_reg[31:0]   + save_reg[31:0]};
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule
